opb_rr_arbiter: RTL and testbench

OPB_RR_ARBITER -- requirements
Module: opb_rr_arbiter

---
 rtl/opb_arb_pkg.sv | 23 ++
 rtl/opb_rr_arbiter_if.sv | 31 +++
 rtl/opb_rr_priority_enc.sv | 27 ++
 rtl/opb_rr_arbiter.sv | 110 +++++++++++
 tb/tb_opb_rr_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/opb_arb_pkg.sv
// Shared types and constants for the OPB round-robin arbiter.
// Pure declarations; no logic, no latency, no flow control.
package opb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2
   } arb_state_t;

   localparam int CNT_W = 8;

   // Index width for n masters; never narrower than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/opb_rr_arbiter_if.sv
// OPB arbitration signal bundle: master requests and slave responses in, grant and status out.
// slave modport faces the arbiter; master modport faces the bus side that drives requests.
interface opb_rr_arbiter_if import opb_arb_pkg::*; #(
   parameter int C_NUM_MASTERS = 4
) ();
   localparam int OW = clog2(C_NUM_MASTERS);

   logic [0:C_NUM_MASTERS-1] M_request;
   logic [0:C_NUM_MASTERS-1] M_busLock;
   logic                     OPB_select;
   logic                     Sl_xferAck;
   logic                     Sl_retry;
   logic                     Sl_errAck;
   logic                     Sl_toutSup;
   logic [0:C_NUM_MASTERS-1] OPB_MGrant;
   logic                     OPB_timeout;
   logic [OW-1:0]            Arb_owner;
   logic                     Arb_busy;

   modport slave (
      input  M_request, M_busLock, OPB_select,
      input  Sl_xferAck, Sl_retry, Sl_errAck, Sl_toutSup,
      output OPB_MGrant, OPB_timeout, Arb_owner, Arb_busy
   );

   modport master (
      output M_request, M_busLock, OPB_select,
      output Sl_xferAck, Sl_retry, Sl_errAck, Sl_toutSup,
      input  OPB_MGrant, OPB_timeout, Arb_owner, Arb_busy
   );
endinterface

// File: rtl/opb_rr_priority_enc.sv
// Rotate-and-find-first: first set request at or after ptr, wrapping past the top index.
// Purely combinational; no flow control.
module opb_rr_priority_enc import opb_arb_pkg::*; #(
   parameter int N = 4,
   localparam int OW = clog2(N)
) (
   input  logic [0:N-1]  req,
   input  logic [OW-1:0] ptr,
   output logic [OW-1:0] idx,
   output logic          vld
);

   always_comb begin
      idx = '0;
      vld = 1'b0;
      for (int i = 0; i < N; i++) begin : g_scan
         int j;
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!vld && req[j]) begin
            idx = OW'(j);
            vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/opb_rr_arbiter.sv
// OPB bus arbiter: round-robin grant, bus-lock retention and bus-timeout detection.
// Grant appears one cycle after a request is seen in IDLE; slaves stall via Sl_toutSup.
module opb_rr_arbiter import opb_arb_pkg::*; #(
   parameter int C_NUM_MASTERS = 4,
   parameter int C_TOUT_CYCLES = 16
) (
   input logic          OPB_Clk,
   input logic          OPB_Rst,
   opb_rr_arbiter_if.slave bus
);

   localparam int             OW        = clog2(C_NUM_MASTERS);
   localparam logic [OW-1:0]  LAST_IDX  = OW'(C_NUM_MASTERS - 1);
   localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(C_TOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   arb_state_t       state_q, state_d;
   logic [OW-1:0]    owner_q, owner_d;
   logic [OW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tout_q, tout_d;

   logic [OW-1:0]    win_idx;
   logic             win_vld;
   logic             any_resp;
   logic [OW-1:0]    owner_inc;

   opb_rr_priority_enc #(.N(C_NUM_MASTERS)) u_prio (
      .req (bus.M_request),
      .ptr (ptr_q),
      .idx (win_idx),
      .vld (win_vld)
   );

   assign any_resp  = bus.Sl_xferAck | bus.Sl_retry | bus.Sl_errAck;
   assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         tout_q  <= tout_d;
      end
   end

   // Counter is only ever non-zero while a transfer is in BUSY.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = '0;
      tout_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               state_d = ST_GRANT;
               owner_d = win_idx;
            end
         end
         ST_GRANT: begin
            if (bus.OPB_select) begin
               state_d = ST_BUSY;
            end else if (!bus.M_request[owner_q]) begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (any_resp) begin
               if (bus.M_busLock[owner_q] && bus.M_request[owner_q]) begin
                  state_d = ST_GRANT;
               end else begin
                  state_d = ST_IDLE;
                  ptr_d   = owner_inc;
               end
            end else if (!bus.OPB_select) begin
               state_d = ST_IDLE;
               ptr_d   = owner_inc;
            end else if (!bus.Sl_toutSup && cnt_q == TOUT_LAST) begin
               state_d = ST_IDLE;
               ptr_d   = owner_inc;
               tout_d  = 1'b1;
            end else if (!bus.Sl_toutSup) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.OPB_MGrant  = '0;
      for (int i = 0; i < C_NUM_MASTERS; i++) begin
         bus.OPB_MGrant[i] = (state_q != ST_IDLE) && (owner_q == OW'(i));
      end
      bus.OPB_timeout = tout_q;
      bus.Arb_owner   = owner_q;
      bus.Arb_busy    = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_opb_rr_arbiter.sv
// Self-checking bench for opb_rr_arbiter: scoreboard of expected grant owners.
module tb_opb_rr_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   int   exp_q[$];

   opb_rr_arbiter_if #(.C_NUM_MASTERS(4)) bus ();

   opb_rr_arbiter #(.C_NUM_MASTERS(4), .C_TOUT_CYCLES(16)) dut (
      .OPB_Clk (clk),
      .OPB_Rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [0:3] onehot(input int i);
      logic [0:3] v;
      v = '0;
      if (i >= 0 && i < 4) v[i] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [0:3] v);
      bus.M_request = v;
   endtask

   task automatic do_xfer();
      bus.OPB_select = 1'b1;
      tick();
      bus.Sl_xferAck = 1'b1;
      tick();
      bus.OPB_select = 1'b0;
      bus.Sl_xferAck = 1'b0;
   endtask

   task automatic grant_step(output logic [0:3] g, output logic [1:0] o, output int want);
      tick();
      g = bus.OPB_MGrant;
      o = bus.Arb_owner;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      else want = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (bus.OPB_MGrant !== 4'b0000 || bus.Arb_owner !== 2'd0) begin
         n_err++;
         $display("FAIL reset_grant: grant=%b owner=%0d want grant=0000 owner=0", bus.OPB_MGrant, bus.Arb_owner);
      end
      n_cmp++;
      if (bus.OPB_timeout !== 1'b0 || bus.Arb_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_status: timeout=%b busy=%b want 0 0", bus.OPB_timeout, bus.Arb_busy);
      end
   endtask

   task automatic test_round_robin();
      logic [0:3] g;
      logic [1:0] o;
      int w;
      set_req(4'b1111);
      tick();
      n_cmp++;
      if (bus.OPB_MGrant !== 4'b0000) begin
         n_err++;
         $display("FAIL rr_held_in_reset: grant=%b want 0000", bus.OPB_MGrant);
      end
      rst = 1'b0;
      exp_q.push_back(0);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL rr_first: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      for (int k = 1; k <= 4; k++) begin
         do_xfer();
         n_cmp++;
         if (bus.OPB_MGrant !== 4'b0000 || bus.Arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL rr_release%0d: grant=%b busy=%b want 0000 0", k, bus.OPB_MGrant, bus.Arb_busy);
         end
         exp_q.push_back(k % 4);
         grant_step(g, o, w);
         n_cmp++;
         if (g !== onehot(w) || o !== 2'(w)) begin
            n_err++;
            $display("FAIL rr_grant%0d: grant=%b owner=%0d want grant=%b owner=%0d", k, g, o, onehot(w), w);
         end
      end
      do_xfer();
      set_req(4'b0000);
      tick();
   endtask

   task automatic test_lock();
      logic [0:3] g;
      logic [1:0] o;
      int w;
      set_req(4'b0010);
      bus.M_busLock = 4'b0010;
      exp_q.push_back(2);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL lock_grant: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      bus.OPB_select = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         bus.Sl_xferAck = 1'b1;
         tick();
         n_cmp++;
         if (bus.OPB_MGrant !== 4'b0010 || bus.Arb_busy !== 1'b1) begin
            n_err++;
            $display("FAIL lock_hold%0d: grant=%b busy=%b want 0010 1", k, bus.OPB_MGrant, bus.Arb_busy);
         end
         bus.Sl_xferAck = 1'b0;
         tick();
      end
      bus.M_busLock = 4'b0000;
      bus.Sl_xferAck = 1'b1;
      tick();
      n_cmp++;
      if (bus.OPB_MGrant !== 4'b0000 || bus.Arb_busy !== 1'b0) begin
         n_err++;
         $display("FAIL lock_drop: grant=%b busy=%b want 0000 0", bus.OPB_MGrant, bus.Arb_busy);
      end
      bus.Sl_xferAck = 1'b0;
      bus.OPB_select = 1'b0;
      set_req(4'b1111);
      exp_q.push_back(3);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL lock_next_ptr: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      set_req(4'b0000);
      tick();
      n_cmp++;
      if (bus.OPB_MGrant !== 4'b0000) begin
         n_err++;
         $display("FAIL grant_withdraw: grant=%b want 0000", bus.OPB_MGrant);
      end
   endtask

   task automatic test_timeout();
      logic [0:3] g;
      logic [1:0] o;
      int w;
      int early;
      set_req(4'b0100);
      exp_q.push_back(1);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL tout_grant: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      bus.OPB_select = 1'b1;
      tick();
      early = 0;
      repeat (15) begin
         tick();
         if (bus.OPB_timeout !== 1'b0 || bus.Arb_busy !== 1'b1) early++;
      end
      n_cmp++;
      if (early !== 0) begin
         n_err++;
         $display("FAIL tout_early: bad_cycles=%0d want 0", early);
      end
      tick();
      n_cmp++;
      if (bus.OPB_timeout !== 1'b1 || bus.OPB_MGrant !== 4'b0000 || bus.Arb_busy !== 1'b0) begin
         n_err++;
         $display("FAIL tout_pulse: timeout=%b grant=%b busy=%b want 1 0000 0",
                  bus.OPB_timeout, bus.OPB_MGrant, bus.Arb_busy);
      end
      set_req(4'b0000);
      bus.OPB_select = 1'b0;
      tick();
      n_cmp++;
      if (bus.OPB_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL tout_one_cycle: timeout=%b want 0", bus.OPB_timeout);
      end
      set_req(4'b1111);
      exp_q.push_back(2);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL tout_next_ptr: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      set_req(4'b0000);
      tick();
   endtask

   task automatic test_tout_sup();
      logic [0:3] g;
      logic [1:0] o;
      int w;
      int bad;
      set_req(4'b1000);
      exp_q.push_back(0);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL sup_grant: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      bus.OPB_select = 1'b1;
      bus.Sl_toutSup = 1'b1;
      tick();
      bad = 0;
      repeat (40) begin
         tick();
         if (bus.OPB_timeout !== 1'b0 || bus.Arb_busy !== 1'b1) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL sup_hold: bad_cycles=%0d want 0", bad);
      end
      bus.Sl_xferAck = 1'b1;
      tick();
      n_cmp++;
      if (bus.OPB_timeout !== 1'b0 || bus.OPB_MGrant !== 4'b0000 || bus.Arb_busy !== 1'b0) begin
         n_err++;
         $display("FAIL sup_release: timeout=%b grant=%b busy=%b want 0 0000 0",
                  bus.OPB_timeout, bus.OPB_MGrant, bus.Arb_busy);
      end
      bus.Sl_xferAck = 1'b0;
      bus.Sl_toutSup = 1'b0;
      bus.OPB_select = 1'b0;
      set_req(4'b0000);
      tick();
   endtask

   task automatic test_ack_at_limit();
      logic [0:3] g;
      logic [1:0] o;
      int w;
      set_req(4'b0100);
      exp_q.push_back(1);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL limit_grant: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      bus.OPB_select = 1'b1;
      tick();
      repeat (15) tick();
      bus.Sl_xferAck = 1'b1;
      tick();
      n_cmp++;
      if (bus.OPB_timeout !== 1'b0 || bus.OPB_MGrant !== 4'b0000 || bus.Arb_busy !== 1'b0) begin
         n_err++;
         $display("FAIL limit_ack_wins: timeout=%b grant=%b busy=%b want 0 0000 0",
                  bus.OPB_timeout, bus.OPB_MGrant, bus.Arb_busy);
      end
      bus.Sl_xferAck = 1'b0;
      bus.OPB_select = 1'b0;
      set_req(4'b0000);
      tick();
      n_cmp++;
      if (bus.OPB_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL limit_no_pulse: timeout=%b want 0", bus.OPB_timeout);
      end
   endtask

   task automatic test_reset_busy();
      logic [0:3] g;
      logic [1:0] o;
      int w;
      set_req(4'b0010);
      exp_q.push_back(2);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL rstb_grant: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      bus.OPB_select = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      n_cmp++;
      if (bus.OPB_MGrant !== 4'b0000 || bus.Arb_busy !== 1'b0 ||
          bus.OPB_timeout !== 1'b0 || bus.Arb_owner !== 2'd0) begin
         n_err++;
         $display("FAIL rstb_outputs: grant=%b busy=%b timeout=%b owner=%0d want 0000 0 0 0",
                  bus.OPB_MGrant, bus.Arb_busy, bus.OPB_timeout, bus.Arb_owner);
      end
      rst = 1'b0;
      bus.OPB_select = 1'b0;
      set_req(4'b0001);
      exp_q.push_back(3);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL rstb_m3: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      set_req(4'b0000);
      tick();
      set_req(4'b0101);
      exp_q.push_back(1);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL rstb_ptr_zero: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
   endtask

   task automatic test_select_drop();
      logic [0:3] g;
      logic [1:0] o;
      int w;
      bus.OPB_select = 1'b1;
      tick();
      bus.OPB_select = 1'b0;
      tick();
      n_cmp++;
      if (bus.OPB_MGrant !== 4'b0000 || bus.Arb_busy !== 1'b0 || bus.OPB_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL drop_release: grant=%b busy=%b timeout=%b want 0000 0 0",
                  bus.OPB_MGrant, bus.Arb_busy, bus.OPB_timeout);
      end
      set_req(4'b1010);
      exp_q.push_back(2);
      grant_step(g, o, w);
      n_cmp++;
      if (g !== onehot(w) || o !== 2'(w)) begin
         n_err++;
         $display("FAIL drop_next_ptr: grant=%b owner=%0d want grant=%b owner=%0d", g, o, onehot(w), w);
      end
      set_req(4'b0000);
      tick();
      n_cmp++;
      if (exp_q.size() !== 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size());
      end
   endtask

   initial begin
      bus.M_request  = '0;
      bus.M_busLock  = '0;
      bus.OPB_select = 1'b0;
      bus.Sl_xferAck = 1'b0;
      bus.Sl_retry   = 1'b0;
      bus.Sl_errAck  = 1'b0;
      bus.Sl_toutSup = 1'b0;
      test_reset();
      test_round_robin();
      test_lock();
      test_timeout();
      test_tout_sup();
      test_ack_at_limit();
      test_reset_busy();
      test_select_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
